// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN image/pixel constants and counter-width helper
package cnn_pkg;

    localparam int WI_DEFAULT    = 8;
    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;

    // Width of a counter able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width wide enough for both image dimensions at default size.
    localparam int CNT_W = $clog2((IMG_W_DEFAULT > IMG_H_DEFAULT) ? IMG_W_DEFAULT : IMG_H_DEFAULT);

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single image-row delay line built on a circular-pointer RAM
module line_buffer
    import cnn_pkg::*;
#(
    parameter int WI    = WI_DEFAULT,
    parameter int DEPTH = IMG_W_DEFAULT
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iEn,
    input  logic [WI-1:0] iData,
    output logic [WI-1:0] oData
);

    localparam int PW = cnt_width(DEPTH);

    logic [WI-1:0] mem [0:DEPTH-1];
    logic [PW-1:0] ptr;

    // The slot about to be overwritten holds the pixel written DEPTH enables ago.
    assign oData = mem[ptr];

    // Storage is never cleared; the window generator gates out stale content.
    always_ff @(posedge iClk) begin
        if (iEn) begin
            mem[ptr] <= iData;
        end
    end

    // Circular write/read pointer, advancing once per accepted pixel.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr <= '0;
        end else if (iEn) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// rtl/conv3x3_window_gen.sv - raster pixel stream to 3x3 sliding-window generator
module conv3x3_window_gen
    import cnn_pkg::*;
#(
    parameter int WI    = WI_DEFAULT,
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iInValid,
    input  logic [WI-1:0]   iInData,
    output logic            oOutValid,
    output logic [3*WI-1:0] oWindowInRow1,
    output logic [3*WI-1:0] oWindowInRow2,
    output logic [3*WI-1:0] oWindowInRow3,
    output logic            oFrameDone
);

    localparam int CW = cnt_width((IMG_W > IMG_H) ? IMG_W : IMG_H);

    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic [WI-1:0]   tap_1row;
    logic [WI-1:0]   tap_2row;
    logic [3*WI-1:0] win1;
    logic [3*WI-1:0] win2;
    logic [3*WI-1:0] win3;
    logic [3*WI-1:0] next1;
    logic [3*WI-1:0] next2;
    logic [3*WI-1:0] next3;
    logic            accept;
    logic            last_col;
    logic            last_row;
    logic            win_ready;

    assign accept    = iInValid && !iRst;
    assign last_col  = (col == CW'(IMG_W - 1));
    assign last_row  = (row == CW'(IMG_H - 1));
    // Only a pixel with two full rows and two full columns behind it closes a window,
    // which also keeps stale line-buffer data out of every valid window.
    assign win_ready = accept && (row >= CW'(2)) && (col >= CW'(2));

    // Oldest column drops out of the top bits; the new column enters at the bottom.
    assign next1 = {win1[2*WI-1:0], tap_2row};
    assign next2 = {win2[2*WI-1:0], tap_1row};
    assign next3 = {win3[2*WI-1:0], iInData};

    line_buffer #(.WI(WI), .DEPTH(IMG_W)) u_lb_row1 (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (accept),
        .iData (iInData),
        .oData (tap_1row)
    );

    line_buffer #(.WI(WI), .DEPTH(IMG_W)) u_lb_row2 (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (accept),
        .iData (tap_1row),
        .oData (tap_2row)
    );

    // Raster position of the next pixel to be accepted; wraps at end of frame.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            col <= '0;
            row <= '0;
        end else if (iInValid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Internal sliding window, shifted on every accepted pixel.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            win1 <= '0;
            win2 <= '0;
            win3 <= '0;
        end else if (iInValid) begin
            win1 <= next1;
            win2 <= next2;
            win3 <= next3;
        end
    end

    // Output window register loads only on complete windows so it holds between them.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOutValid     <= 1'b0;
            oFrameDone    <= 1'b0;
            oWindowInRow1 <= '0;
            oWindowInRow2 <= '0;
            oWindowInRow3 <= '0;
        end else begin
            oOutValid  <= win_ready;
            oFrameDone <= iInValid && last_col && last_row;
            if (win_ready) begin
                oWindowInRow1 <= next1;
                oWindowInRow2 <= next2;
                oWindowInRow3 <= next3;
            end
        end
    end

endmodule
